// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
// Receives start/data/parity/stop frames from a qualified serial bit stream
// (idle-high line). It assembles DATA_W-bit words MSB- or LSB-first, checks
// even parity and the stop bit, and presents good words on a valid/ready
// holding register. Sticky error flags record every dropped word.
//
// Handshake: a word is transferred on any rising clk edge where
// data_valid && data_ready. data_out is held stable while data_valid=1 and
// data_ready=0. A new word may load on the same edge that drains the old one.
//
// dbg_state exposes the FSM state (0=IDLE, 1=DATA, 2=PARITY, 3=STOP).

module serial_frame_deserializer #(
   parameter int DATA_W    = 8,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              si,
   input  logic              lsb_first,
   input  logic              data_ready,
   input  logic              err_clr,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              busy,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun,
   output logic [1:0]        dbg_state
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_shreg;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_lsb;       // bit order latched at start-bit detect
   logic              r_xor;       // running XOR of the data bits
   logic              r_par_bad;
   logic [DATA_W-1:0] r_data_out;
   logic              r_valid;
   logic              r_perr;
   logic              r_ferr;
   logic              r_ovr;

   // Frame FSM, shift register, holding register and sticky error flags.
   // Error clears are written first so a same-cycle error set overrides them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_shreg    <= '0;
         r_cnt      <= '0;
         r_lsb      <= 1'b0;
         r_xor      <= 1'b0;
         r_par_bad  <= 1'b0;
         r_data_out <= '0;
         r_valid    <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_ovr      <= 1'b0;
      end else begin
         if (err_clr) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
         end
         if (r_valid && data_ready) begin
            r_valid <= 1'b0;
         end
         if (bit_en) begin
            case (r_state)
               S_IDLE: begin
                  if (!si) begin
                     r_state   <= S_DATA;
                     r_lsb     <= lsb_first;
                     r_cnt     <= '0;
                     r_xor     <= 1'b0;
                     r_par_bad <= 1'b0;
                  end
               end
               S_DATA: begin
                  if (r_lsb) begin
                     r_shreg <= {si, r_shreg[DATA_W-1:1]};
                  end else begin
                     r_shreg <= {r_shreg[DATA_W-2:0], si};
                  end
                  r_xor <= r_xor ^ si;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == LAST_CNT) begin
                     r_state <= PARITY_EN ? S_PARITY : S_STOP;
                  end
               end
               S_PARITY: begin
                  r_par_bad <= r_xor ^ si;
                  r_state   <= S_STOP;
               end
               S_STOP: begin
                  r_state <= S_IDLE;
                  if (!si) begin
                     r_ferr <= 1'b1;
                  end else if (r_par_bad) begin
                     r_perr <= 1'b1;
                  end else if (!r_valid || data_ready) begin
                     r_data_out <= r_shreg;
                     r_valid    <= 1'b1;
                  end else begin
                     r_ovr <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_valid;
   assign busy       = (r_state != S_IDLE);
   assign parity_err = r_perr;
   assign frame_err  = r_ferr;
   assign overrun    = r_ovr;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// tb_serial_frame_deserializer
// Directed bench for serial_frame_deserializer (DATA_W=8, PARITY_EN=1).
// A table of single frames with hand-computed results, followed by
// hand-written sequences for backpressure, overrun, reset mid-frame,
// set-wins error clearing and bit_en gaps.

module tb_serial_frame_deserializer;

   logic       clk;
   logic       rst;
   logic       bit_en;
   logic       si;
   logic       lsb_first;
   logic       data_ready;
   logic       err_clr;
   logic [7:0] data_out;
   logic       data_valid;
   logic       busy;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   serial_frame_deserializer #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_en     (bit_en),
      .si         (si),
      .lsb_first  (lsb_first),
      .data_ready (data_ready),
      .err_clr    (err_clr),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .dbg_state  (dbg_state)
   );

   // clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // seq[7] is the first data bit on the wire, seq[0] the last.
   typedef struct {
      logic [7:0] seq;
      logic       lsb;
      logic       par;
      logic       stop;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one qualified bit, preceded by max_gap-bounded random idle cycles
   task automatic send_bit(input logic b, input int max_gap);
      int gap;
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int g = 0; g < gap; g++) begin
         bit_en = 1'b0;
         si     = 1'($urandom_range(1, 0));
         tick();
      end
      bit_en = 1'b1;
      si     = b;
      tick();
      bit_en = 1'b0;
      si     = 1'b1;
   endtask

   // start bit, eight data bits, parity bit (stop bit sent separately)
   task automatic send_body(input logic [7:0] seq, input logic par, input int max_gap);
      send_bit(1'b0, max_gap);
      for (int i = 7; i >= 0; i--) begin
         send_bit(seq[i], max_gap);
      end
      send_bit(par, max_gap);
   endtask

   task automatic send_frame(input logic [7:0] seq, input logic par, input logic stop, input int max_gap);
      send_body(seq, par, max_gap);
      send_bit(stop, max_gap);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      bit_en     = 1'b0;
      si         = 1'b1;
      lsb_first  = 1'b1;
      data_ready = 1'b1;
      err_clr    = 1'b0;

      //               seq           lsb   par   stop  valid dat    perr  ferr
      vecs[0] = '{8'b0111_1000, 1'b1, 1'b0, 1'b1, 1'b1, 8'h1E, 1'b0, 1'b0};
      vecs[1] = '{8'b0111_1000, 1'b0, 1'b0, 1'b1, 1'b1, 8'h78, 1'b0, 1'b0};
      vecs[2] = '{8'b0111_1000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[3] = '{8'b0111_1000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
      vecs[4] = '{8'b1010_0000, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0};
      vecs[5] = '{8'b1100_0001, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC1, 1'b0, 1'b0};
      vecs[6] = '{8'b1100_0001, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{8'b1111_1111, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[8] = '{8'b0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
      vecs[9] = '{8'b0000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

      repeat (2) tick();
      rst = 1'b0;

      // reset state
      chk("rst_busy",  16'(busy), 16'h0);
      chk("rst_valid", 16'(data_valid), 16'h0);
      chk("rst_data",  16'(data_out), 16'h0);
      chk("rst_flags", 16'({parity_err, frame_err, overrun}), 16'h0);
      chk("rst_state", 16'(dbg_state), 16'h0);

      // idle-high line does nothing
      send_bit(1'b1, 0);
      chk("idle_busy", 16'(busy), 16'h0);

      // table of single frames, data_ready held high
      for (int v = 0; v < 10; v++) begin
         lsb_first = vecs[v].lsb;
         send_body(vecs[v].seq, vecs[v].par, 0);
         chk($sformatf("v%0d_pre_valid", v), 16'(data_valid), 16'h0);
         chk($sformatf("v%0d_busy", v), 16'(busy), 16'h1);
         send_bit(vecs[v].stop, 0);
         chk($sformatf("v%0d_valid", v), 16'(data_valid), 16'(vecs[v].exp_valid));
         if (vecs[v].exp_valid)
            chk($sformatf("v%0d_data", v), 16'(data_out), 16'(vecs[v].exp_data));
         chk($sformatf("v%0d_perr", v), 16'(parity_err), 16'(vecs[v].exp_perr));
         chk($sformatf("v%0d_ferr", v), 16'(frame_err), 16'(vecs[v].exp_ferr));
         chk($sformatf("v%0d_ovr", v), 16'(overrun), 16'h0);
         chk($sformatf("v%0d_idle", v), 16'(busy), 16'h0);
         tick();
         chk($sformatf("v%0d_valid_drop", v), 16'(data_valid), 16'h0);
         pulse_clr();
         chk($sformatf("v%0d_clr", v), 16'({parity_err, frame_err, overrun}), 16'h0);
      end

      // lsb_first toggled mid-frame must not affect the latched order
      lsb_first = 1'b0;
      send_bit(1'b0, 0);
      chk("tog_state", 16'(dbg_state), 16'h1);
      lsb_first = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'((8'b0111_1000 >> i) & 8'h1), 0);
         lsb_first = ~lsb_first;
      end
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      chk("tog_valid", 16'(data_valid), 16'h1);
      chk("tog_data", 16'(data_out), 16'h78);
      tick();

      // set wins over err_clr in the same cycle
      lsb_first = 1'b1;
      send_frame(8'b0111_1000, 1'b1, 1'b1, 0);
      chk("sw_perr_set", 16'(parity_err), 16'h1);
      send_body(8'b0111_1000, 1'b0, 0);
      err_clr = 1'b1;
      send_bit(1'b0, 0);
      err_clr = 1'b0;
      chk("sw_ferr", 16'(frame_err), 16'h1);
      chk("sw_perr_clr", 16'(parity_err), 16'h0);
      pulse_clr();

      // backpressure and overrun, back-to-back frames
      data_ready = 1'b0;
      lsb_first  = 1'b1;
      send_frame(8'b0111_1000, 1'b0, 1'b1, 0);
      lsb_first  = 1'b0;
      send_frame(8'b0111_1000, 1'b0, 1'b1, 0);
      chk("bp_valid", 16'(data_valid), 16'h1);
      chk("bp_data", 16'(data_out), 16'h1E);
      chk("bp_ovr", 16'(overrun), 16'h1);
      tick();
      chk("bp_hold", 16'(data_out), 16'h1E);
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      chk("bp_drain", 16'(data_valid), 16'h0);
      chk("bp_ovr_sticky", 16'(overrun), 16'h1);
      pulse_clr();

      // good frame arrives on the same edge that drains a held word
      lsb_first = 1'b1;
      send_frame(8'b0111_1000, 1'b0, 1'b1, 0);
      chk("dr_held", 16'(data_out), 16'h1E);
      send_body(8'b1010_0000, 1'b0, 0);
      data_ready = 1'b1;
      send_bit(1'b1, 0);
      data_ready = 1'b0;
      chk("dr_valid", 16'(data_valid), 16'h1);
      chk("dr_data", 16'(data_out), 16'h05);
      chk("dr_ovr", 16'(overrun), 16'h0);
      data_ready = 1'b1;
      tick();
      chk("dr_drop", 16'(data_valid), 16'h0);

      // reset mid-frame with a held word present
      data_ready = 1'b0;
      send_frame(8'b1111_1111, 1'b0, 1'b1, 0);
      send_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_busy", 16'(busy), 16'h0);
      chk("mr_valid", 16'(data_valid), 16'h0);
      chk("mr_data", 16'(data_out), 16'h0);
      chk("mr_flags", 16'({parity_err, frame_err, overrun}), 16'h0);
      data_ready = 1'b1;
      lsb_first  = 1'b1;
      send_frame(8'b0111_1000, 1'b0, 1'b1, 0);
      chk("mr_after_valid", 16'(data_valid), 16'h1);
      chk("mr_after_data", 16'(data_out), 16'h1E);
      tick();
      chk("mr_after_drop", 16'(data_valid), 16'h0);

      // bit_en gaps of 0-3 cycles between bits
      for (int r = 0; r < 4; r++) begin
         lsb_first = 1'b1;
         send_body(8'b0111_1000, 1'b0, 3);
         chk($sformatf("gap%0d_pre", r), 16'(data_valid), 16'h0);
         send_bit(1'b1, 3);
         chk($sformatf("gap%0d_valid", r), 16'(data_valid), 16'h1);
         chk($sformatf("gap%0d_data", r), 16'(data_out), 16'h1E);
         chk($sformatf("gap%0d_flags", r), 16'({parity_err, frame_err, overrun}), 16'h0);
         tick();
         chk($sformatf("gap%0d_drop", r), 16'(data_valid), 16'h0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
